// File: rtl/rvfi_seq_pkg.sv
// Shared types for the RVFI retire sequencer: error codes, FSM states and
// the reorder-window slot entry.
package rvfi_seq_pkg;

    // Widest payload a slot entry can carry; instances use the low PAYLOAD_W bits.
    localparam int SLOT_PAYLOAD_W = 64;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_WINDOW = 2'd1,
        ERR_DUP    = 2'd2,
        ERR_GAP    = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_e;

    typedef struct packed {
        logic                      occ;
        logic                      halt;
        logic [SLOT_PAYLOAD_W-1:0] payload;
    } slot_t;

    // Resolve simultaneous error conditions: window beats duplicate beats gap.
    function automatic err_code_e pick_error(input logic win, input logic dup, input logic gap);
        if (win)      return ERR_WINDOW;
        else if (dup) return ERR_DUP;
        else if (gap) return ERR_GAP;
        else          return ERR_NONE;
    endfunction

endpackage

// File: rtl/rvfi_seq_window.sv
// Reorder window: DEPTH slots indexed by the low order bits, NRET write
// ports, one combinational read port with clear, and per-slot occupancy.
module rvfi_seq_window
    import rvfi_seq_pkg::*;
#(
    parameter int NRET      = 1,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32,
    parameter int IW        = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NRET-1:0]           wr_en,
    input  logic [NRET*IW-1:0]        wr_idx,
    input  logic [NRET-1:0]           wr_halt,
    input  logic [NRET*PAYLOAD_W-1:0] wr_payload,
    input  logic [IW-1:0]             rd_idx,
    input  logic                      rd_clr,
    output slot_t                     rd_entry,
    output logic [DEPTH-1:0]          occ
);

    logic                 halt_mem [DEPTH];
    logic [PAYLOAD_W-1:0] pay_mem  [DEPTH];

    // Occupancy: drain clears the read slot, writes set their slots. The
    // top never writes the slot being drained in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ <= '0;
        end else begin
            if (rd_clr) occ[rd_idx] <= 1'b0;
            for (int i = 0; i < NRET; i++) begin
                if (wr_en[i]) occ[wr_idx[i*IW +: IW]] <= 1'b1;
            end
        end
    end

    // Slot contents are only meaningful while occ is set, so they carry no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NRET; i++) begin
            if (wr_en[i]) begin
                halt_mem[wr_idx[i*IW +: IW]] <= wr_halt[i];
                pay_mem[wr_idx[i*IW +: IW]]  <= wr_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Present the slot at the read index as a full entry.
    always_comb begin
        rd_entry                         = '0;
        rd_entry.occ                     = occ[rd_idx];
        rd_entry.halt                    = halt_mem[rd_idx];
        rd_entry.payload[PAYLOAD_W-1:0]  = pay_mem[rd_idx];
    end

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// Accepts out-of-order retirements on NRET channels and re-emits them one
// per cycle in ascending rvfi_order, flagging window, duplicate and gap errors.
module rvfi_retire_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET      = 1,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NRET-1:0]           in_valid,
    input  logic [64*NRET-1:0]        in_order,
    input  logic [NRET-1:0]           in_halt,
    input  logic [PAYLOAD_W*NRET-1:0] in_payload,
    output logic                      out_valid,
    output logic [63:0]               out_order,
    output logic                      out_halt,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic                      halted,
    output logic                      err,
    output logic [1:0]                err_code
);

    localparam int IW = $clog2(DEPTH);

    state_e            state_q, state_d;
    err_code_e         err_code_d;
    logic [63:0]       exp_q;
    logic [15:0]       gap_q;
    logic [DEPTH-1:0]  occ;
    slot_t             rd_entry;
    logic [NRET-1:0]   wr_ok, wr_en;
    logic [NRET*IW-1:0] wr_idx;
    logic              win_err, dup_err, gap_err, gap_hit, clash, drain, any_err;
    logic [63:0]       ch_order [NRET];
    logic              unused_payload_hi;

    for (genvar g = 0; g < NRET; g++) begin : g_split
        assign ch_order[g] = in_order[64*g +: 64];
    end

    // Upper slot payload bits beyond PAYLOAD_W are always zero.
    assign unused_payload_hi = ^rd_entry.payload;

    rvfi_seq_window #(
        .NRET(NRET), .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .IW(IW)
    ) u_window (
        .clock(clock),
        .reset(reset),
        .wr_en(wr_en),
        .wr_idx(wr_idx),
        .wr_halt(in_halt),
        .wr_payload(in_payload),
        .rd_idx(exp_q[IW-1:0]),
        .rd_clr(drain),
        .rd_entry(rd_entry),
        .occ(occ)
    );

    // Classify each valid channel against the expected order at cycle start.
    always_comb begin
        win_err = 1'b0;
        dup_err = 1'b0;
        clash   = 1'b0;
        wr_ok   = '0;
        wr_idx  = '0;
        for (int i = 0; i < NRET; i++) begin
            wr_idx[i*IW +: IW] = ch_order[i][IW-1:0];
            if (in_valid[i] && state_q == S_RUN) begin
                if (ch_order[i] < exp_q) begin
                    dup_err = 1'b1;
                end else if ({1'b0, ch_order[i]} >= ({1'b0, exp_q} + 65'(DEPTH))) begin
                    win_err = 1'b1;
                end else begin
                    clash = 1'b0;
                    for (int j = 0; j < NRET; j++) begin
                        if (j != i && in_valid[j] && ch_order[j] == ch_order[i]) clash = 1'b1;
                    end
                    if (occ[ch_order[i][IW-1:0]] || clash) dup_err = 1'b1;
                    else                                   wr_ok[i] = 1'b1;
                end
            end
        end
        drain   = (state_q == S_RUN) && rd_entry.occ;
        gap_hit = (state_q == S_RUN) && (|occ) && !rd_entry.occ;
        gap_err = gap_hit && (({1'b0, gap_q} + 17'd1) >= 17'(TIMEOUT));
        any_err = win_err || dup_err || gap_err;
        wr_en   = any_err ? '0 : wr_ok;
    end

    // FSM next state: errors win over a halt drain in the same cycle.
    always_comb begin
        state_d    = state_q;
        err_code_d = ERR_NONE;
        case (state_q)
            S_RUN: begin
                err_code_d = pick_error(win_err, dup_err, gap_err);
                if (err_code_d != ERR_NONE)       state_d = S_ERROR;
                else if (drain && rd_entry.halt)  state_d = S_HALTED;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // Expected order, gap counter, sticky flags and the registered output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            exp_q       <= '0;
            gap_q       <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            halted      <= 1'b0;
            out_valid   <= 1'b0;
            out_order   <= '0;
            out_halt    <= 1'b0;
            out_payload <= '0;
        end else begin
            out_valid <= drain;
            if (drain) begin
                out_order   <= exp_q;
                out_halt    <= rd_entry.halt;
                out_payload <= rd_entry.payload[PAYLOAD_W-1:0];
                exp_q       <= exp_q + 64'd1;
            end
            gap_q <= gap_hit ? gap_q + 16'd1 : 16'd0;
            if (state_q == S_RUN && any_err) begin
                err      <= 1'b1;
                err_code <= err_code_d;
            end
            if (state_q == S_RUN && state_d == S_HALTED) halted <= 1'b1;
        end
    end

endmodule

// File: doc/rvfi_retire_sequencer.md
# rvfi_retire_sequencer

Upstream stage of the RVFI checkers: accepts up to NRET retirements per cycle, in any order across channels and cycles, and re-emits them on one channel in strict ascending rvfi_order, one per cycle. The liveness and order-based checkers consume this single in-order stream. The block also raises sticky, coded errors for out-of-window, duplicate and gap (stall) conditions so that bench assertions have one place to look.

## Interface
- NRET, 1: number of input retirement channels.
- DEPTH, 8: reorder window in instructions; a power of two, at least 2.
- PAYLOAD_W, 32: width of the opaque per-instruction payload carried through unchanged.
- TIMEOUT, 16: gap timeout in cycles; range 1..65535.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  NRET  per-channel retirement strobe
- in_order  in  64*NRET  per-channel rvfi_order; channel i occupies [64*i +: 64]
- in_halt  in  NRET  per-channel rvfi_halt
- in_payload  in  PAYLOAD_W*NRET  per-channel payload
- out_valid  out  1  in-order retirement strobe
- out_order  out  64  order of the emitted instruction
- out_halt  out  1  halt flag of the emitted instruction
- out_payload  out  PAYLOAD_W  payload of the emitted instruction
- halted  out  1  a halt instruction has been emitted
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 out-of-window, 2 duplicate, 3 gap timeout

## Operation
- State: expected order `exp` (64 bit, reset 0), slot array of DEPTH entries indexed by order[log2(DEPTH)-1:0], each entry holding occ/halt/payload, and a gap counter (16 bit).
- FSM states are RUN, HALTED and ERROR. Reset enters RUN.
- Classification in RUN, per valid channel, against the `exp` value at the start of the cycle:
  - order < exp: duplicate.
  - order ≥ exp+DEPTH: out-of-window. The comparison uses 65-bit arithmetic, so there is no wrap.
  - slot already occupied, or two channels carry the same order in the same cycle: duplicate.
  - otherwise: write the slot and set occ.
- Drain in RUN: if slot[exp].occ is set, register it to the outputs with out_valid=1 and out_order=exp, clear occ, and increment exp. At most one drain per cycle.
- Gap counter:
  - increments when any occ is set and slot[exp].occ is 0;
  - clears otherwise;
  - reaching TIMEOUT raises code 3.
- Error handling:
  - The first error latches err=1 and the code, then moves to ERROR.
  - When several errors occur in the same cycle, priority is 1 > 2 > 3.
  - In ERROR, out_valid stays 0 and all inputs are ignored until reset.
- Halt: draining an entry with halt=1 emits it normally, then moves to HALTED. In HALTED, halted=1, out_valid stays 0, and inputs are ignored with no errors raised.
- Reset values: out_valid 0, out_order 0, out_halt 0, out_payload 0, halted 0, err 0, err_code 0, all occ 0, gap counter 0.

## Timing
- Minimum latency is 1 cycle: a retirement presented at edge t is output at edge t+1 at the earliest. There is no combinational in→out path.
- A write and a drain in the same cycle are independent. The drain reads the slot state as it was before the edge, so a retirement with order==exp appearing at t is emitted at t+1, never at t.
- Throughput is one output per cycle. With NRET>1, bursts accumulate in the window; sustained input above one per cycle eventually triggers out-of-window.
- Reset asserted mid-stream clears the window, `exp`, errors and halted at that edge. Inputs in the reset cycle are dropped.
- All outputs are registered. err and err_code become visible the cycle after the offending input or timeout.

## Structure
- Package rvfi_seq_pkg holds:
  - the err_code enum (ERR_NONE, ERR_WINDOW, ERR_DUP, ERR_GAP);
  - the state enum (S_RUN, S_HALTED, S_ERROR);
  - the slot entry struct (occ, halt, payload).
- Sub-module rvfi_seq_window holds the slot array with its NRET write ports and one read/clear port, and exports per-slot occ. Classification, the FSM, `exp` and the gap counter live in the top level.

## Test plan
- NRET=2, DEPTH=8: ch0 order 1 and ch1 order 0 in cycle 0 → out_order 0 at cycle 1 and 1 at cycle 2; err stays 0.
- Order 0 at cycle 0, then order 0 again at cycle 3 → err=1, err_code=2 at cycle 4; out_valid stays 0 afterwards.
- Order 8 presented with exp=0 and DEPTH=8 → err_code=1 the next cycle; no output.
- Order 1 only, TIMEOUT=16 → err_code=3 after 16 gap cycles; a late order 0 is ignored.
- Orders 0, 1 and 2, with halt set on 1 → outputs 0 and 1 emitted, then halted=1; order 2 is never emitted and err stays 0.
- Orders 0..3 streamed, reset pulsed at cycle 2, then order 0 presented → out_order 0 is emitted again and exp restarts at 0.
